im_loader: RTL and testbench

- Program loader that writes the instruction memory the fetch stage reads from.
- Accepts a byte stream over a valid/ready handshake, assembles little-endian 32-bit words, and issues one-cycle word writes at consecutive word indices starting at index 0 (byte address BASE_ADDR).
- Holds the CPU via cpu_hold while loading, then releases it.
- Sits between the board/testbench byte source and the IM write port.

---
 rtl/im_loader.sv | 153 +++++++++++++++
 tb/tb_im_loader.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/im_loader.sv
// Instruction-memory program loader: assembles a little-endian byte stream
// into 32-bit words and writes them to consecutive IM word indices, holding
// the CPU while the load is in progress.
module im_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_3000,
  parameter int          DEPTH     = 4096,
  parameter int          ADDR_W    = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [12:0]       len,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic [31:0]       im_byte_addr,
  output logic              busy,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_WRITE   = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  localparam logic [12:0] DEPTH_LEN = 13'(DEPTH);

  state_t            state_q,    state_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;   // byte position within the word
  logic [23:0]       asm_q,      asm_d;        // first three bytes of the word
  logic [12:0]       idx_q,      idx_d;        // next word index == words written
  logic [12:0]       len_q,      len_d;        // latched word count for this load
  logic [ADDR_W-1:0] addr_q,     addr_d;       // write address, held between writes
  logic [31:0]       wdata_q,    wdata_d;      // write data, held between writes
  logic              done_q,     done_d;
  logic              err_q,      err_d;

  logic              start_ok;

  // State register; every flop clears on the asynchronous reset.
  // NOTE: sequential state uses non-blocking assignments so all flops update
  // together from values computed before the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      byte_cnt_q <= '0;
      asm_q      <= '0;
      idx_q      <= '0;
      len_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      asm_q      <= asm_d;
      idx_q      <= idx_d;
      len_q      <= len_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  // Next-state logic: start handling, byte assembly and word sequencing.
  always_comb begin
    // NOTE: every signal gets its hold value first so no path leaves a
    // variable unassigned, which would otherwise infer a latch.
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    asm_d      = asm_q;
    idx_d      = idx_q;
    len_d      = len_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    done_d     = done_q;
    err_d      = err_q;

    start_ok = (len != 13'd0) && (len <= DEPTH_LEN);

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          done_d = 1'b0;
          if (start_ok) begin
            len_d      = len;
            idx_d      = '0;
            byte_cnt_d = '0;
            asm_d      = '0;
            err_d      = 1'b0;
            state_d    = S_COLLECT;
          end else begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end
        end
      end

      S_COLLECT: begin
        if (byte_valid) begin
          byte_cnt_d = byte_cnt_q + 2'd1;
          unique case (byte_cnt_q)
            2'd0: asm_d[7:0]   = byte_data;
            2'd1: asm_d[15:8]  = byte_data;
            2'd2: asm_d[23:16] = byte_data;
            2'd3: begin
              wdata_d = {byte_data, asm_q};
              addr_d  = idx_q[ADDR_W-1:0];
              state_d = S_WRITE;
            end
            default: ;
          endcase
        end
      end

      S_WRITE: begin
        idx_d = idx_q + 13'd1;
        if ((idx_q + 13'd1) == len_q) begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          state_d = S_COLLECT;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decode directly from registered state, so im_we never follows
  // byte_valid combinationally.
  always_comb begin
    byte_ready   = (state_q == S_COLLECT);
    im_we        = (state_q == S_WRITE);
    busy         = (state_q == S_COLLECT) || (state_q == S_WRITE);
    cpu_hold     = busy;
    done         = done_q;
    err          = err_q;
    im_addr      = addr_q;
    im_wdata     = wdata_q;
    im_byte_addr = BASE_ADDR + {{(30 - ADDR_W){1'b0}}, addr_q, 2'b00};
  end

endmodule

// File: tb/tb_im_loader.sv
// Self-checking bench for im_loader: reset state, directed latency sequence,
// a table of start-legality vectors, and randomized loads compared against a
// word-level model of the byte stream.
module tb_im_loader;

  localparam logic [31:0] BASE = 32'h0000_3000;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [12:0] len;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        im_we;
  logic [11:0] im_addr;
  logic [31:0] im_wdata;
  logic [31:0] im_byte_addr;
  logic        busy;
  logic        cpu_hold;
  logic        done;
  logic        err;

  im_loader dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .len          (len),
    .byte_valid   (byte_valid),
    .byte_data    (byte_data),
    .byte_ready   (byte_ready),
    .im_we        (im_we),
    .im_addr      (im_addr),
    .im_wdata     (im_wdata),
    .im_byte_addr (im_byte_addr),
    .busy         (busy),
    .cpu_hold     (cpu_hold),
    .done         (done),
    .err          (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] addr;
    logic [31:0] data;
    logic [31:0] baddr;
    logic        rdy;
  } wr_t;

  typedef struct {
    logic [12:0] len;
    logic        exp_err;
    logic        exp_busy;
    logic        exp_done;
  } vec_t;

  wr_t        wr_q[$];
  logic [7:0] stim[$];
  int         n_checks = 0;
  int         n_errors = 0;
  int         done_rises = 0;
  int         hold_diff = 0;
  logic       done_prev = 1'b0;

  // Write monitor, sampled on the falling edge between active edges.
  always @(negedge clk) begin
    if (im_we) wr_q.push_back('{im_addr, im_wdata, im_byte_addr, byte_ready});
    if (cpu_hold !== busy) hold_diff <= hold_diff + 1;
    if (done && !done_prev) done_rises <= done_rises + 1;
    done_prev <= done;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  // Start pulse; len is scrambled afterwards since it must only be sampled on start.
  task automatic pulse_start(input logic [12:0] l);
    start = 1'b1;
    len   = l;
    tick();
    start = 1'b0;
    len   = 13'($urandom);
  endtask

  task automatic gen_stim(input int nbytes);
    stim.delete();
    for (int i = 0; i < nbytes; i++) stim.push_back(8'($urandom));
  endtask

  // Streams stim[from..to-1], inserting idle cycles with probability gap%.
  task automatic send_range(input int from, input int to, input int gap);
    int i = from;
    int budget = 0;
    while (i < to && budget < 64 * (to - from) + 100) begin
      if ($urandom_range(99) < gap) begin
        byte_valid = 1'b0;
        byte_data  = 8'($urandom);
      end else begin
        byte_valid = 1'b1;
        byte_data  = stim[i];
        if (byte_ready) i++;
      end
      tick();
      budget++;
    end
    byte_valid = 1'b0;
    check("bytes_accepted", 32'(i), 32'(to));
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!done && n < budget) begin
      tick();
      n++;
    end
    check_bit("done_seen", done, 1'b1);
  endtask

  // Model: word w is stim[4w..4w+3] little-endian, at index w.
  task automatic check_writes(input int base, input int l);
    int bad = 0;
    logic [31:0] exp_data, exp_baddr;
    check("write_count", 32'(wr_q.size() - base), 32'(l));
    if (wr_q.size() - base != l) return;
    for (int w = 0; w < l; w++) begin
      exp_data  = 32'(stim[4*w]) + (32'(stim[4*w+1]) << 8)
                + (32'(stim[4*w+2]) << 16) + (32'(stim[4*w+3]) << 24);
      exp_baddr = BASE + 32'(4 * w);
      if (l <= 8) begin
        check("wr_addr",  32'(wr_q[base+w].addr), 32'(w));
        check("wr_data",  wr_q[base+w].data, exp_data);
        check("wr_baddr", wr_q[base+w].baddr, exp_baddr);
        check_bit("wr_ready_low", wr_q[base+w].rdy, 1'b0);
      end else if (wr_q[base+w].addr !== 12'(w) || wr_q[base+w].data !== exp_data
                   || wr_q[base+w].baddr !== exp_baddr || wr_q[base+w].rdy !== 1'b0) begin
        bad++;
      end
    end
    if (l > 8) check("bad_words", 32'(bad), 32'd0);
  endtask

  task automatic run_load(input int l, input int gap);
    int base  = wr_q.size();
    int rises = done_rises;
    gen_stim(4 * l);
    pulse_start(13'(l));
    send_range(0, 4 * l, gap);
    wait_done(50);
    check_writes(base, l);
    check("done_rises", 32'(done_rises - rises), 32'd1);
    check_bit("busy_after", busy, 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    check_bit({tag, "_ready"}, byte_ready, 1'b0);
    check_bit({tag, "_we"}, im_we, 1'b0);
    check({tag, "_addr"}, 32'(im_addr), 32'd0);
    check({tag, "_wdata"}, im_wdata, 32'd0);
    check({tag, "_baddr"}, im_byte_addr, BASE);
    check_bit({tag, "_busy"}, busy, 1'b0);
    check_bit({tag, "_hold"}, cpu_hold, 1'b0);
    check_bit({tag, "_done"}, done, 1'b0);
    check_bit({tag, "_err"}, err, 1'b0);
  endtask

  initial begin
    vec_t vecs[6];
    int   base;
    int   rises;
    int   n;

    vecs[0] = '{13'd0,    1'b1, 1'b0, 1'b0};
    vecs[1] = '{13'd4097, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{13'd1,    1'b0, 1'b1, 1'b0};
    vecs[3] = '{13'd8191, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{13'd4096, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{13'd5000, 1'b1, 1'b0, 1'b0};

    reset = 1'b1; start = 1'b0; len = '0; byte_valid = 1'b0; byte_data = '0;
    tick();
    check_all_zero("reset");
    reset = 1'b0;
    tick();

    // Directed len=1 sequence with back-to-back bytes and exact latency.
    base = wr_q.size();
    pulse_start(13'd1);
    check_bit("d1_busy", busy, 1'b1);
    check_bit("d1_ready", byte_ready, 1'b1);
    byte_valid = 1'b1;
    byte_data = 8'h78; tick();
    byte_data = 8'h56; tick();
    byte_data = 8'h34; tick();
    byte_data = 8'h12; tick();
    byte_valid = 1'b0;
    check_bit("d1_we", im_we, 1'b1);
    check("d1_addr", 32'(im_addr), 32'd0);
    check("d1_wdata", im_wdata, 32'h1234_5678);
    check("d1_baddr", im_byte_addr, 32'h0000_3000);
    check_bit("d1_ready_in_write", byte_ready, 1'b0);
    check_bit("d1_hold_in_write", cpu_hold, 1'b1);
    tick();
    check_bit("d1_done", done, 1'b1);
    check_bit("d1_busy_after", busy, 1'b0);
    check_bit("d1_we_after", im_we, 1'b0);
    check("d1_wdata_hold", im_wdata, 32'h1234_5678);
    check("d1_writes", 32'(wr_q.size() - base), 32'd1);

    // Start-legality table, applied starting from the DONE state.
    foreach (vecs[v]) begin
      base = wr_q.size();
      pulse_start(vecs[v].len);
      check_bit("vec_err", err, vecs[v].exp_err);
      check_bit("vec_busy", busy, vecs[v].exp_busy);
      check_bit("vec_ready", byte_ready, vecs[v].exp_busy);
      check_bit("vec_done", done, vecs[v].exp_done);
      if (vecs[v].exp_busy) begin
        do_reset();
      end else begin
        tick();
        tick();
        check("vec_no_write", 32'(wr_q.size() - base), 32'd0);
      end
    end

    // len=3 with random valid gaps.
    run_load(3, 40);

    // Second start while loading is ignored.
    base  = wr_q.size();
    rises = done_rises;
    gen_stim(12);
    pulse_start(13'd3);
    send_range(0, 8, 25);
    n = 0;
    while (wr_q.size() - base < 2 && n < 20) begin
      tick();
      n++;
    end
    check("mid_two_written", 32'(wr_q.size() - base), 32'd2);
    pulse_start(13'd2);
    check_bit("mid_still_busy", busy, 1'b1);
    send_range(8, 12, 25);
    wait_done(50);
    check_writes(base, 3);
    check("mid_done_rises", 32'(done_rises - rises), 32'd1);

    // Asynchronous reset in the middle of word 1.
    gen_stim(8);
    pulse_start(13'd2);
    send_range(0, 6, 0);
    #1 reset = 1'b1;
    #1 check_all_zero("async_rst");
    tick();
    reset = 1'b0;
    tick();
    base = wr_q.size();
    byte_valid = 1'b1;
    byte_data  = 8'hA5;
    for (int i = 0; i < 3; i++) begin
      check_bit("idle_ready_low", byte_ready, 1'b0);
      tick();
    end
    byte_valid = 1'b0;
    check("idle_no_write", 32'(wr_q.size() - base), 32'd0);
    run_load(1, 30);

    // Randomized loads against the model.
    for (int r = 0; r < 6; r++) run_load($urandom_range(1, 6), $urandom_range(0, 60));

    // Full-depth load.
    base = wr_q.size();
    run_load(4096, 0);
    check("full_last_addr", 32'(wr_q[wr_q.size()-1].addr), 32'h0000_0FFF);
    check("full_last_baddr", wr_q[wr_q.size()-1].baddr, 32'h0000_6FFC);
    for (int i = 0; i < 20; i++) tick();
    check("full_no_extra_write", 32'(wr_q.size() - base), 32'd4096);
    check_bit("full_done_held", done, 1'b1);

    check("cpu_hold_vs_busy", 32'(hold_diff), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
